// File: rtl/counter_bank_pkg.sv
// Shared constants and next-state function for the counter bank channels.
// Values are carried at CNT_W bits so one function serves every channel width.
package counter_bank_pkg;

   localparam int CNT_W    = 64;
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic             tc;
   } next_t;

   // Priority load > en; bounds are 0 and 2^width-1 of the channel's own width.
   function automatic next_t next_count(
      input logic [CNT_W-1:0] cnt,
      input logic             en,
      input logic             dir,
      input logic             load,
      input logic [CNT_W-1:0] load_val,
      input int               width,
      input logic             sat
   );
      logic [CNT_W-1:0] max_v;
      next_t            r;
      max_v = {CNT_W{1'b1}} >> (CNT_W - width);
      r.cnt = cnt;
      r.tc  = 1'b0;
      if (load) begin
         r.cnt = load_val;
      end else if (en) begin
         if (dir == DIR_UP) begin
            if (cnt != max_v) begin
               r.cnt = cnt + 64'd1;
            end else begin
               r.cnt = sat ? max_v : '0;
               r.tc  = 1'b1;
            end
         end else begin
            if (cnt != '0) begin
               r.cnt = cnt - 64'd1;
            end else begin
               r.cnt = sat ? '0 : max_v;
               r.tc  = 1'b1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/counter_bank_ch.sv
// One counter channel: count register, terminal-count register and LED tap.
module counter_bank_ch
   import counter_bank_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int LED_W    = 4,
   parameter int LED_LSB  = 22,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_dir,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc,
   output logic [LED_W-1:0] o_led
);

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   next_t            w_next;

   always_comb begin
      w_next = next_count(CNT_W'(r_count), i_en, i_dir, i_load,
                          CNT_W'(i_load_val), WIDTH, SATURATE == MODE_SAT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_tc    <= 1'b0;
      end else begin
         r_count <= WIDTH'(w_next.cnt);
         r_tc    <= w_next.tc;
      end
   end

   // LED tap is a plain slice of the count register, no extra stage.
   assign o_count = r_count;
   assign o_tc    = r_tc;
   assign o_led   = r_count[LED_LSB +: LED_W];

endmodule

// File: rtl/counter_bank.sv
// Multi-channel counter bank: one independent counter_bank_ch per channel,
// packed onto flat buses with channel i at [i*WIDTH +: WIDTH].
module counter_bank
   import counter_bank_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 2,
   parameter int LED_W    = 4,
   parameter int LED_LSB  = 22,
   parameter int SATURATE = MODE_WRAP
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       dir,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] load_val,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       tc,
   output logic [CHANNELS*LED_W-1:0] io_led
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      counter_bank_ch #(
         .WIDTH   (WIDTH),
         .LED_W   (LED_W),
         .LED_LSB (LED_LSB),
         .SATURATE(SATURATE)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .i_en      (en[g]),
         .i_dir     (dir[g]),
         .i_load    (load[g]),
         .i_load_val(load_val[g*WIDTH +: WIDTH]),
         .o_count   (count[g*WIDTH +: WIDTH]),
         .o_tc      (tc[g]),
         .o_led     (io_led[g*LED_W +: LED_W])
      );
   end

endmodule

// File: doc/counter_bank.md
Name: counter_bank

Overview:
- Parametrised multi-channel free-running counter bank. Next generation of the board-level LED counter used in the interchange test designs.
- Adds per-channel enable, direction, parallel load, wrap/saturate mode and a terminal-count pulse.
- Drives a selectable LED tap per channel.
- Sits directly behind the board clock buffer; all logic is in one clock domain.

Parameters:
- WIDTH, 32: counter width per channel, in bits (2..64).
- CHANNELS, 2: number of independent counters (1..8).
- LED_W, 4: LED tap width per channel.
- LED_LSB, 22: LSB index of the LED tap. Constraint: LED_LSB+LED_W <= WIDTH.
- SATURATE, 0: 0 = wrap at bounds; 1 = hold at bounds.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  CHANNELS  per-channel count enable.
- dir  in  CHANNELS  per-channel direction: 0 = up, 1 = down.
- load  in  CHANNELS  per-channel parallel-load strobe.
- load_val  in  CHANNELS*WIDTH  load values; channel i occupies bits [i*WIDTH +: WIDTH].
- count  out  CHANNELS*WIDTH  current counter values, packed as load_val.
- tc  out  CHANNELS  registered terminal-count pulse.
- io_led  out  CHANNELS*LED_W  channel i = count_i[LED_LSB +: LED_W].

Behaviour:
- Reset is synchronous, active-high: reset is sampled only on the rising edge of clk, with no asynchronous path.
- While rst=1 at a clk edge, each channel gets count=0, tc=0, io_led=0, regardless of en, load or dir.
- Per-channel update at each rising edge, in priority order rst > load > en:
  - load=1: count <= load_val_i; tc <= 0. en and dir are ignored.
  - else en=1, dir=0 (up):
    - count != MAX (2^WIDTH-1): count+1.
    - count == MAX, SATURATE=0: count <= 0, tc <= 1.
    - count == MAX, SATURATE=1: count stays MAX, tc <= 1.
  - else en=1, dir=1 (down):
    - count != 0: count-1.
    - count == 0, SATURATE=0: count <= MAX, tc <= 1.
    - count == 0, SATURATE=1: count stays 0, tc <= 1.
  - else (en=0): count holds; tc <= 0.
- tc is 1 for exactly the cycle after a bound event. In saturate mode it re-asserts every enabled cycle spent at the bound.
- Latency:
  - count changes one cycle after the qualifying edge.
  - io_led is combinational from the count register; no extra register.
- Arithmetic is modulo 2^WIDTH; there is no sign.
- A dir change takes effect on the same edge it is sampled. No hysteresis.
- Simultaneous load and bound event: load wins, tc=0.
- Channels are fully independent; no cross-channel carry.
- First clock after rst deasserts: count 0 -> 1 if en=1 and dir=0.
- rst asserted mid-count: count returns to 0 on that edge; the prior value is lost.
- Default-parameter instance with en=1, dir=0, load=0 is cycle-equivalent to the existing single-channel 32-bit LED counter on io_led[3:0].

Decomposition:
- Package counter_bank_pkg holds:
  - MODE_WRAP and MODE_SAT constants.
  - DIR_UP and DIR_DOWN constants.
  - A function computing the next count and tc from (count, en, dir, load, load_val, SATURATE).
- Sub-module counter_bank_ch: one channel (register, next-state logic, tc register, LED tap).
- Top level: generate loop over CHANNELS plus bus packing.

Test Plan:
- WIDTH=4, CHANNELS=2, SATURATE=0, LED_LSB=0, LED_W=4. rst held 2 cycles, then en=2'b01, dir=0 for 17 cycles.
  - Ch0 count goes 0..15, then 0. tc0=1 only in the cycle after 15->0.
  - Ch1 stays 0. io_led[3:0] tracks ch0.
- Same config. load=1 with load_val=4'h3 on ch0, then en=1, dir=1 for 5 cycles.
  - Ch0 count 3,2,1,0,15. tc0 pulses once, after 0->15.
- SATURATE=1, WIDTH=4. Load 14, then en=1, dir=0 for 4 cycles.
  - Ch0 count 15,15,15,15. tc0=1 in each of the 3 cycles following arrival at 15.
- Same cycle: load=1 (load_val=9) and en=1 with count=15, dir=0.
  - Next count=9 and tc=0. Load has priority.
- Count ch0 to 7, then assert rst for 1 cycle with en=1 and load=1.
  - Next cycle count=0, tc=0, io_led=0. Counting resumes 1,2,... after rst drops.
- Default parameters, 2^24 cycles with en=1.
  - io_led[3:0] equals count[25:22] every cycle. tc stays 0.
